native_mem_initiator: RTL and testbench

NATIVE_MEM_INITIATOR -- requirements
Module: native_mem_initiator

---
 rtl/native_mem_initiator.sv | 164 ++++++++++++++++
 tb/tb_native_mem_initiator.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/native_mem_initiator.sv
// Native memory bus initiator: one outstanding command, misalignment and
// timeout errors, saturating error counter.
module native_mem_initiator #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_instr,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_valid,
    output logic        mem_instr,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 32'd1);

    state_t      state_r, state_s;
    logic        cmd_ready_r, mem_valid_r, mem_instr_r;
    logic [31:0] mem_addr_r, mem_wdata_r, rsp_rdata_r;
    logic [3:0]  mem_wstrb_r;
    logic        rsp_valid_r, rsp_err_r;
    logic [7:0]  err_count_r, tmo_cnt_r;
    logic        accept_s, aligned_s, bus_ok_s, bus_tmo_s, rsp_done_s, err_rsp_s;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign aligned_s = (cmd_addr[1:0] == 2'b00);
    assign err_rsp_s = (accept_s && !aligned_s) || bus_tmo_s;

    // Next-state decode; ready wins over timeout in the last REQ cycle
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        bus_ok_s   = 1'b0;
        bus_tmo_s  = 1'b0;
        rsp_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (cmd_valid && cmd_ready_r) begin
                    accept_s = 1'b1;
                    if (aligned_s) begin
                        state_s = REQ;
                    end else begin
                        state_s = RESP;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    bus_ok_s = 1'b1;
                    state_s  = RESP;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    bus_tmo_s = 1'b1;
                    state_s   = RESP;
                end else begin
                    state_s = REQ;
                end
            end
            RESP: begin
                if (rsp_valid_r && rsp_ready) begin
                    rsp_done_s = 1'b1;
                    state_s    = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Bus, response and error-count registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_ready_r <= 1'b0;
            mem_valid_r <= 1'b0;
            mem_instr_r <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_wdata_r <= 32'h0000_0000;
            mem_wstrb_r <= 4'b0000;
            tmo_cnt_r   <= 8'd0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            err_count_r <= 8'd0;
        end else begin
            cmd_ready_r <= (state_s == IDLE);
            if (accept_s && aligned_s) begin
                mem_valid_r <= 1'b1;
                mem_instr_r <= cmd_instr;
                mem_addr_r  <= cmd_addr;
                mem_wdata_r <= cmd_wdata;
                mem_wstrb_r <= cmd_wstrb;
                tmo_cnt_r   <= 8'd0;
            end else if (bus_ok_s || bus_tmo_s) begin
                mem_valid_r <= 1'b0;
                mem_wstrb_r <= 4'b0000;
            end else if (state_r == REQ) begin
                tmo_cnt_r <= tmo_cnt_r + 8'd1;
            end
            if (accept_s && !aligned_s) begin
                rsp_valid_r <= 1'b1;
                rsp_err_r   <= 1'b1;
                rsp_rdata_r <= 32'h0000_0000;
            end else if (bus_ok_s) begin
                rsp_valid_r <= 1'b1;
                rsp_err_r   <= 1'b0;
                rsp_rdata_r <= (mem_wstrb_r == 4'b0000) ? mem_rdata : 32'h0000_0000;
            end else if (bus_tmo_s) begin
                rsp_valid_r <= 1'b1;
                rsp_err_r   <= 1'b1;
                rsp_rdata_r <= 32'h0000_0000;
            end else if (rsp_done_s) begin
                rsp_valid_r <= 1'b0;
            end
            if (err_rsp_s) begin
                err_count_r <= sat_inc(err_count_r);
            end
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign mem_valid = mem_valid_r;
    assign mem_instr = mem_instr_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_wstrb = mem_wstrb_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;
    assign rsp_rdata = rsp_rdata_r;
    assign err_count = err_count_r;

endmodule

// File: tb/tb_native_mem_initiator.sv
// Directed and LFSR-driven bench for native_mem_initiator, using a default
// instance (TIMEOUT=255) and a short-timeout instance (TIMEOUT=4).
module tb_native_mem_initiator;

    logic        clk = 1'b0;
    logic        reset, cmd_valid_a, cmd_valid_b, cmd_instr, rsp_ready, mem_ready;
    logic [31:0] cmd_addr, cmd_wdata, mem_rdata;
    logic [3:0]  cmd_wstrb;

    logic        cmd_ready_a, rsp_valid_a, rsp_err_a, mem_valid_a, mem_instr_a;
    logic [31:0] rsp_rdata_a, mem_addr_a, mem_wdata_a;
    logic [3:0]  mem_wstrb_a;
    logic [7:0]  err_count_a;
    logic        cmd_ready_b, rsp_valid_b, rsp_err_b, mem_valid_b, mem_instr_b;
    logic [31:0] rsp_rdata_b, mem_addr_b, mem_wdata_b;
    logic [3:0]  mem_wstrb_b;
    logic [7:0]  err_count_b;

    logic        sel4 = 1'b0;
    logic        o_cmd_ready, o_rsp_valid, o_rsp_err, o_mem_valid, o_mem_instr;
    logic [31:0] o_rsp_rdata, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_wstrb;
    logic [7:0]  o_err_count;

    int n_cmp = 0;
    int n_fail = 0;
    int errc_a = 0;
    int errc_b = 0;

    always #5 clk = ~clk;

    native_mem_initiator dut_a (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
        .cmd_instr(cmd_instr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a),
        .mem_valid(mem_valid_a), .mem_instr(mem_instr_a), .mem_ready(mem_ready), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_wstrb(mem_wstrb_a), .mem_rdata(mem_rdata), .err_count(err_count_a)
    );

    native_mem_initiator #(.TIMEOUT(4)) dut_b (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
        .cmd_instr(cmd_instr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
        .mem_valid(mem_valid_b), .mem_instr(mem_instr_b), .mem_ready(mem_ready), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_wstrb(mem_wstrb_b), .mem_rdata(mem_rdata), .err_count(err_count_b)
    );

    assign o_cmd_ready = sel4 ? cmd_ready_b : cmd_ready_a;
    assign o_rsp_valid = sel4 ? rsp_valid_b : rsp_valid_a;
    assign o_rsp_err   = sel4 ? rsp_err_b   : rsp_err_a;
    assign o_rsp_rdata = sel4 ? rsp_rdata_b : rsp_rdata_a;
    assign o_mem_valid = sel4 ? mem_valid_b : mem_valid_a;
    assign o_mem_instr = sel4 ? mem_instr_b : mem_instr_a;
    assign o_mem_addr  = sel4 ? mem_addr_b  : mem_addr_a;
    assign o_mem_wdata = sel4 ? mem_wdata_b : mem_wdata_a;
    assign o_mem_wstrb = sel4 ? mem_wstrb_b : mem_wstrb_a;
    assign o_err_count = sel4 ? err_count_b : err_count_a;

    typedef struct {
        bit          use4;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          ready_at;
        logic [31:0] rdata;
        int          hold;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_vc;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // One command start to finish; ready_at = valid cycle in which mem_ready is high (0: never)
    task automatic txn(input bit use4, input logic instr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb, input int ready_at,
                       input logic [31:0] rdata, input int hold, input logic exp_err,
                       input logic [31:0] exp_rdata, input int exp_vc, input string tag);
        int vc = 0;
        int n = 1;
        bit seen = 1'b0;
        int exp_cnt;
        sel4 = use4;
        #1;
        check({tag, " cmd_ready idle"}, o_cmd_ready, 1);
        cmd_valid_a = !use4;
        cmd_valid_b = use4;
        cmd_instr = instr;
        cmd_addr = addr;
        cmd_wdata = wdata;
        cmd_wstrb = wstrb;
        mem_rdata = rdata;
        @(negedge clk);
        cmd_valid_a = 1'b0;
        cmd_valid_b = 1'b0;
        while (!seen && n <= 300) begin
            mem_ready = 1'b0;
            if (o_rsp_valid) begin
                seen = 1'b1;
            end else begin
                if (o_mem_valid) begin
                    vc++;
                    check({tag, " mem_addr"}, o_mem_addr, addr);
                    check({tag, " mem_wdata"}, o_mem_wdata, wdata);
                    check({tag, " mem_wstrb"}, o_mem_wstrb, wstrb);
                    check({tag, " mem_instr"}, o_mem_instr, instr);
                    mem_ready = (vc == ready_at);
                end
                @(negedge clk);
                n++;
            end
        end
        mem_ready = 1'b0;
        check({tag, " rsp_valid seen"}, seen, 1);
        check({tag, " valid cycles"}, vc, exp_vc);
        check({tag, " rsp latency"}, n, exp_vc + 1);
        check({tag, " rsp_err"}, o_rsp_err, exp_err);
        check({tag, " rsp_rdata"}, o_rsp_rdata, exp_rdata);
        check({tag, " mem_valid low"}, o_mem_valid, 0);
        check({tag, " mem_wstrb low"}, o_mem_wstrb, 0);
        if (exp_err) begin
            if (use4) errc_b = (errc_b < 255) ? errc_b + 1 : 255;
            else      errc_a = (errc_a < 255) ? errc_a + 1 : 255;
        end
        exp_cnt = use4 ? errc_b : errc_a;
        check({tag, " err_count"}, o_err_count, exp_cnt);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, " hold rsp_valid"}, o_rsp_valid, 1);
            check({tag, " hold rsp_rdata"}, o_rsp_rdata, exp_rdata);
            check({tag, " hold rsp_err"}, o_rsp_err, exp_err);
            check({tag, " hold cmd_ready"}, o_cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, " rsp_valid cleared"}, o_rsp_valid, 0);
        check({tag, " cmd_ready back"}, o_cmd_ready, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] lf, r1, r2, r3, r4, r5;
        logic [31:0] addr, rd, er;
        logic [3:0]  ws;
        logic        mis, ee;
        int          rdy, hold, evc;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'b0000, 1, 32'hDEAD_BEEF, 0, 1'b0, 32'hDEAD_BEEF, 1};
        vecs[1] = '{1'b0, 1'b0, 32'h0000_0004, 32'h1234_5678, 4'b0011, 6, 32'hCAFE_F00D, 0, 1'b0, 32'h0, 6};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_0006, 32'h0, 4'b0000, 1, 32'h1, 0, 1'b1, 32'h0, 0};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'b0000, 0, 32'h1111_1111, 0, 1'b1, 32'h0, 4};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_0024, 32'h0, 4'b0000, 4, 32'h2222_2222, 0, 1'b0, 32'h2222_2222, 4};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0, 4'b0000, 2, 32'h55AA_55AA, 10, 1'b0, 32'h55AA_55AA, 2};
        vecs[6] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 4'b1111, 3, 32'h7777_7777, 1, 1'b0, 32'h0, 3};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0003, 32'h9, 4'b1000, 1, 32'h3, 0, 1'b1, 32'h0, 0};
        vecs[8] = '{1'b1, 1'b0, 32'h0000_0028, 32'h0, 4'b0000, 1, 32'h0BAD_F00D, 2, 1'b0, 32'h0BAD_F00D, 1};

        reset = 1'b1;
        cmd_valid_a = 1'b0; cmd_valid_b = 1'b0; cmd_instr = 1'b0;
        cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'b0000;
        rsp_ready = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        check("reset cmd_ready", {cmd_ready_a, cmd_ready_b}, 0);
        check("reset mem_valid", {mem_valid_a, mem_valid_b}, 0);
        check("reset rsp_valid", {rsp_valid_a, rsp_valid_b}, 0);
        check("reset rsp_err", {rsp_err_a, rsp_err_b}, 0);
        check("reset mem_addr", mem_addr_a | mem_addr_b, 0);
        check("reset mem_wstrb", {mem_wstrb_a, mem_wstrb_b}, 0);
        check("reset rsp_rdata", rsp_rdata_a | rsp_rdata_b, 0);
        check("reset err_count", {err_count_a, err_count_b}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post-reset cmd_ready", {cmd_ready_a, cmd_ready_b}, 2'b11);

        // Stray mem_ready with no request outstanding must do nothing
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("idle ready ignored mem_valid", {mem_valid_a, mem_valid_b}, 0);
        check("idle ready ignored rsp_valid", {rsp_valid_a, rsp_valid_b}, 0);
        mem_ready = 1'b0;

        for (int i = 0; i < 9; i++) begin
            txn(vecs[i].use4, vecs[i].instr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                vecs[i].ready_at, vecs[i].rdata, vecs[i].hold, vecs[i].exp_err,
                vecs[i].exp_rdata, vecs[i].exp_vc, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 300; i++) begin
            txn(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'b0000, 0, 32'h0, 0, 1'b1, 32'h0, 4,
                $sformatf("sat%0d", i));
        end
        check("err_count saturated", err_count_b, 8'd255);

        // Reset pulse in the middle of a pending request
        sel4 = 1'b0;
        cmd_valid_a = 1'b1; cmd_addr = 32'h0000_0030; cmd_wstrb = 4'b0101; cmd_wdata = 32'h1;
        @(negedge clk);
        cmd_valid_a = 1'b0;
        repeat (3) @(negedge clk);
        check("mid-REQ mem_valid", mem_valid_a, 1);
        reset = 1'b1;
        @(negedge clk);
        check("reset-in-REQ mem_valid", mem_valid_a, 0);
        check("reset-in-REQ rsp_valid", rsp_valid_a, 0);
        check("reset-in-REQ cmd_ready", cmd_ready_a, 0);
        check("reset-in-REQ mem_wstrb", mem_wstrb_a, 0);
        check("reset-in-REQ err_count", {err_count_a, err_count_b}, 0);
        reset = 1'b0;
        errc_a = 0;
        errc_b = 0;
        @(negedge clk);
        check("after reset cmd_ready", cmd_ready_a, 1);
        for (int i = 0; i < 3; i++) begin
            check("after reset no rsp_valid", rsp_valid_a, 0);
            @(negedge clk);
        end

        lf = 16'hACE1;
        for (int i = 0; i < 1000; i++) begin
            lf = lfsr_next(lf); r1 = lf;
            lf = lfsr_next(lf); r2 = lf;
            lf = lfsr_next(lf); r3 = lf;
            lf = lfsr_next(lf); r4 = lf;
            lf = lfsr_next(lf); r5 = lf;
            addr = {r1, r2[15:2], 2'b00};
            mis = (r3[2:0] == 3'b000);
            if (mis) addr[1:0] = (r3[4:3] == 2'b00) ? 2'b10 : r3[4:3];
            ws = r3[5] ? r3[9:6] : 4'b0000;
            rdy = int'(r3[12:10]);
            hold = int'(r3[14:13]) % 3;
            rd = {r4, r5};
            if (mis) begin
                ee = 1'b1; er = 32'h0; evc = 0;
            end else if (rdy >= 1 && rdy <= 4) begin
                ee = 1'b0; er = (ws == 4'b0000) ? rd : 32'h0; evc = rdy;
            end else begin
                ee = 1'b1; er = 32'h0; evc = 4;
            end
            txn(1'b1, r3[15], addr, {r5, r4}, ws, rdy, rd, hold, ee, er, evc,
                $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
